// File: rtl/loop_playback.sv
// loop_playback: streams recorded samples from a synchronous-read sample
// memory, one per audio strobe, with optional looping and a half-amplitude
// echo tap mixed in with saturation.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | stopped, position held at 0, waiting for play with length
// ARMED      | playing, waiting for the next audio strobe
// FETCH_MAIN | reading the sample at pos (READ_LATENCY+1 cycles)
// FETCH_ECHO | reading the sample at pos-ECHO_DELAY (READ_LATENCY+1 cycles)
// EMIT       | register mixed sample, advance or finish
// DONE       | one-shot finished, waiting for play to drop
module loop_playback #(
  parameter int ADDR_WIDTH   = 16,
  parameter int SAMPLE_WIDTH = 8,
  parameter int READ_LATENCY = 2,
  parameter int ECHO_DELAY   = 3000
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           play_in,
  input  logic                           loop_in,
  input  logic                           echo_en_in,
  input  logic [ADDR_WIDTH-1:0]          length_in,
  input  logic                           audio_valid_in,
  output logic [ADDR_WIDTH-1:0]          mem_addr_out,
  input  logic signed [SAMPLE_WIDTH-1:0] mem_data_in,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           sample_valid_out,
  output logic [ADDR_WIDTH-1:0]          position_out,
  output logic                           busy_out,
  output logic                           done_out,
  output logic                           overrun_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_FETCH_MAIN,
    S_FETCH_ECHO,
    S_EMIT,
    S_DONE
  } state_t;

  localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] ECHO_OFS = ADDR_WIDTH'(ECHO_DELAY);
  localparam logic signed [SAMPLE_WIDTH-1:0] SAT_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [SAMPLE_WIDTH-1:0] SAT_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

  state_t                          state_q, state_d;
  logic [ADDR_WIDTH-1:0]           pos_q, pos_d;
  logic [ADDR_WIDTH-1:0]           len_q, len_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]           mem_addr_q, mem_addr_d;
  logic signed [SAMPLE_WIDTH-1:0]  main_q, main_d;
  logic signed [SAMPLE_WIDTH-1:0]  echo_q, echo_d;
  logic signed [SAMPLE_WIDTH-1:0]  sample_q, sample_d;
  logic                            sample_valid_q, sample_valid_d;
  logic                            done_q, done_d;
  logic                            overrun_q, overrun_d;

  logic signed [SAMPLE_WIDTH-1:0]  echo_half;
  logic [SAMPLE_WIDTH:0]           mix_sum;
  logic signed [SAMPLE_WIDTH-1:0]  mix_sat;
  logic [ADDR_WIDTH-1:0]           pos_inc;

  // Mix main sample with half the echo sample, one bit of headroom, clamp on overflow.
  always_comb begin
    echo_half = echo_q >>> 1;
    mix_sum   = {main_q[SAMPLE_WIDTH-1], main_q} + {echo_half[SAMPLE_WIDTH-1], echo_half};
    mix_sat   = mix_sum[SAMPLE_WIDTH-1:0];
    if (mix_sum[SAMPLE_WIDTH] != mix_sum[SAMPLE_WIDTH-1]) begin
      mix_sat = mix_sum[SAMPLE_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  // Next-state and datapath updates; play_in low aborts ahead of any strobe.
  always_comb begin
    state_d        = state_q;
    pos_d          = pos_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    mem_addr_d     = mem_addr_q;
    main_d         = main_q;
    echo_d         = echo_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    done_d         = 1'b0;
    overrun_d      = overrun_q;
    pos_inc        = pos_q + 1'b1;

    if (audio_valid_in &&
        (state_q == S_FETCH_MAIN || state_q == S_FETCH_ECHO || state_q == S_EMIT)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        pos_d = '0;
        if (play_in && (length_in != '0)) begin
          len_d   = length_in;
          state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        if (!play_in) begin
          state_d = S_IDLE;
          pos_d   = '0;
        end else if (audio_valid_in) begin
          mem_addr_d = pos_q;
          cnt_d      = CNT_LOAD;
          state_d    = S_FETCH_MAIN;
        end
      end

      S_FETCH_MAIN: begin
        if (!play_in) begin
          state_d = S_IDLE;
          pos_d   = '0;
        end else if (cnt_q == '0) begin
          main_d = mem_data_in;
          if (echo_en_in && (pos_q >= ECHO_OFS)) begin
            mem_addr_d = pos_q - ECHO_OFS;
            cnt_d      = CNT_LOAD;
            state_d    = S_FETCH_ECHO;
          end else begin
            echo_d  = '0;
            state_d = S_EMIT;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FETCH_ECHO: begin
        if (!play_in) begin
          state_d = S_IDLE;
          pos_d   = '0;
        end else if (cnt_q == '0) begin
          echo_d  = mem_data_in;
          state_d = S_EMIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_EMIT: begin
        if (!play_in) begin
          state_d = S_IDLE;
          pos_d   = '0;
        end else begin
          sample_d       = mix_sat;
          sample_valid_d = 1'b1;
          if (pos_inc < len_q) begin
            pos_d   = pos_inc;
            state_d = S_ARMED;
          end else if (loop_in) begin
            pos_d   = '0;
            state_d = S_ARMED;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (!play_in) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        pos_d   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q        <= S_IDLE;
      pos_q          <= '0;
      len_q          <= '0;
      cnt_q          <= '0;
      mem_addr_q     <= '0;
      main_q         <= '0;
      echo_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      mem_addr_q     <= mem_addr_d;
      main_q         <= main_d;
      echo_q         <= echo_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      done_q         <= done_d;
      overrun_q      <= overrun_d;
    end
  end

  assign mem_addr_out     = mem_addr_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = sample_valid_q;
  assign position_out     = pos_q;
  assign busy_out         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_out         = done_q;
  assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_loop_playback.sv
// Directed bench for loop_playback with a two-stage read-latency memory model.
module tb_loop_playback;
  localparam int AW = 16;
  localparam int SW = 8;
  localparam int RL = 2;
  localparam int ED = 2;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          play_in;
  logic          loop_in;
  logic          echo_en_in;
  logic [AW-1:0] length_in;
  logic          audio_valid_in;
  logic [AW-1:0] mem_addr_out;
  logic [SW-1:0] mem_data_in;
  logic [SW-1:0] sample_out;
  logic          sample_valid_out;
  logic [AW-1:0] position_out;
  logic          busy_out;
  logic          done_out;
  logic          overrun_out;

  logic [SW-1:0] mem [0:65535];
  logic [SW-1:0] rd1, rd2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  // Memory read port model: address to data in RL cycles.
  always @(posedge clk_in) begin
    rd1 <= mem[mem_addr_out];
    rd2 <= rd1;
  end
  assign mem_data_in = rd2;

  loop_playback #(
    .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW), .READ_LATENCY(RL), .ECHO_DELAY(ED)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .play_in(play_in), .loop_in(loop_in),
    .echo_en_in(echo_en_in), .length_in(length_in), .audio_valid_in(audio_valid_in),
    .mem_addr_out(mem_addr_out), .mem_data_in(mem_data_in), .sample_out(sample_out),
    .sample_valid_out(sample_valid_out), .position_out(position_out),
    .busy_out(busy_out), .done_out(done_out), .overrun_out(overrun_out)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic strobe();
    audio_valid_in = 1'b1;
    tick();
    audio_valid_in = 1'b0;
  endtask

  // Runs n cycles, reporting first valid latency/value and pulse counts.
  task automatic watch(input int n, output int lat, output logic [SW-1:0] val,
                       output int nval, output int ndone);
    lat = -1; val = '0; nval = 0; ndone = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (sample_valid_out) begin
        if (lat < 0) begin
          lat = i;
          val = sample_out;
        end
        nval++;
      end
      if (done_out) ndone++;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; play_in = 1'b1; audio_valid_in = 1'b1; length_in = 16'd5;
    repeat (3) tick();
    n_vec++; if (mem_addr_out !== '0) begin n_err++; $display("FAIL reset_addr: got %0h want 0", mem_addr_out); end
    n_vec++; if (sample_out !== '0) begin n_err++; $display("FAIL reset_sample: got %0h want 0", sample_out); end
    n_vec++; if (position_out !== '0) begin n_err++; $display("FAIL reset_pos: got %0d want 0", position_out); end
    n_vec++; if (sample_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", sample_valid_out); end
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    n_vec++; if (done_out !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_out); end
    n_vec++; if (overrun_out !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun_out); end
    audio_valid_in = 1'b0; play_in = 1'b0; rst_in = 1'b1;
    tick();
  endtask

  task automatic test_one_shot();
    int lat, nv, nd;
    logic [SW-1:0] v;
    for (int i = 0; i < 4; i++) mem[i] = SW'(i + 1);
    length_in = 16'd4; loop_in = 1'b0; echo_en_in = 1'b0; play_in = 1'b1;
    tick();
    n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL oneshot_busy: got %b want 1", busy_out); end
    for (int k = 0; k < 4; k++) begin
      strobe();
      watch(99, lat, v, nv, nd);
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL oneshot_lat[%0d]: got %0d want 4", k, lat); end
      n_vec++; if (v !== SW'(k + 1)) begin n_err++; $display("FAIL oneshot_val[%0d]: got %0d want %0d", k, v, k + 1); end
      n_vec++; if (nv !== 1) begin n_err++; $display("FAIL oneshot_nvalid[%0d]: got %0d want 1", k, nv); end
      n_vec++; if (nd !== ((k == 3) ? 1 : 0)) begin n_err++; $display("FAIL oneshot_done[%0d]: got %0d want %0d", k, nd, (k == 3) ? 1 : 0); end
      n_vec++; if (mem_addr_out !== AW'(k)) begin n_err++; $display("FAIL oneshot_addr[%0d]: got %0d want %0d", k, mem_addr_out, k); end
      if (k < 3) begin
        n_vec++; if (position_out !== AW'(k + 1)) begin n_err++; $display("FAIL oneshot_pos[%0d]: got %0d want %0d", k, position_out, k + 1); end
      end
    end
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL oneshot_done_busy: got %b want 0", busy_out); end
    strobe();
    watch(20, lat, v, nv, nd);
    n_vec++; if (nv !== 0) begin n_err++; $display("FAIL oneshot_extra: got %0d samples want 0", nv); end
    play_in = 1'b0;
    tick(); tick();
    n_vec++; if (position_out !== '0) begin n_err++; $display("FAIL oneshot_pos_end: got %0d want 0", position_out); end
  endtask

  task automatic test_loop();
    int lat, nv, nd, nd_total;
    logic [SW-1:0] v;
    logic [SW-1:0] exp3 [3];
    exp3[0] = 8'd10; exp3[1] = 8'd20; exp3[2] = 8'd30;
    for (int i = 0; i < 3; i++) mem[i] = exp3[i];
    length_in = 16'd3; loop_in = 1'b1; echo_en_in = 1'b0; play_in = 1'b1;
    nd_total = 0;
    tick();
    for (int k = 0; k < 6; k++) begin
      strobe();
      watch(99, lat, v, nv, nd);
      nd_total += nd;
      n_vec++; if (v !== exp3[k % 3] || lat !== 4) begin n_err++; $display("FAIL loop_val[%0d]: got %0d at %0d want %0d at 4", k, v, lat, exp3[k % 3]); end
      n_vec++; if (position_out !== AW'((k + 1) % 3)) begin n_err++; $display("FAIL loop_pos[%0d]: got %0d want %0d", k, position_out, (k + 1) % 3); end
    end
    n_vec++; if (nd_total !== 0) begin n_err++; $display("FAIL loop_done: got %0d pulses want 0", nd_total); end
    play_in = 1'b0; loop_in = 1'b0;
    tick(); tick();
  endtask

  task automatic test_echo_sat();
    int lat, nv, nd;
    logic [SW-1:0] v, base, sat;
    for (int p = 0; p < 2; p++) begin
      base = (p == 0) ? 8'd100 : 8'h9C;
      sat  = (p == 0) ? 8'h7F  : 8'h80;
      for (int i = 0; i < 3; i++) mem[i] = base;
      length_in = 16'd3; loop_in = 1'b0; echo_en_in = 1'b1; play_in = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
        strobe();
        watch(99, lat, v, nv, nd);
        n_vec++; if (v !== ((k < 2) ? base : sat)) begin n_err++; $display("FAIL echo_val[%0d][%0d]: got %0h want %0h", p, k, v, (k < 2) ? base : sat); end
        n_vec++; if (lat !== ((k < 2) ? 4 : 7)) begin n_err++; $display("FAIL echo_lat[%0d][%0d]: got %0d want %0d", p, k, lat, (k < 2) ? 4 : 7); end
      end
      n_vec++; if (mem_addr_out !== '0) begin n_err++; $display("FAIL echo_addr[%0d]: got %0d want 0", p, mem_addr_out); end
      n_vec++; if (nd !== 1) begin n_err++; $display("FAIL echo_done[%0d]: got %0d want 1", p, nd); end
      play_in = 1'b0; echo_en_in = 1'b0;
      tick(); tick();
    end
  endtask

  task automatic test_abort();
    int lat, nv, nd;
    logic [SW-1:0] v;
    for (int i = 0; i < 4; i++) mem[i] = SW'(i + 5);
    length_in = 16'd4; play_in = 1'b1;
    tick();
    strobe();
    watch(99, lat, v, nv, nd);
    n_vec++; if (v !== 8'd5 || position_out !== 16'd1) begin n_err++; $display("FAIL abort_pre: got val %0d pos %0d want 5 pos 1", v, position_out); end
    strobe();
    tick(); tick();
    play_in = 1'b0;
    watch(20, lat, v, nv, nd);
    n_vec++; if (nv !== 0) begin n_err++; $display("FAIL abort_valid: got %0d samples want 0", nv); end
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy_out); end
    n_vec++; if (position_out !== '0) begin n_err++; $display("FAIL abort_pos: got %0d want 0", position_out); end
  endtask

  task automatic test_zero_length();
    int lat, nv, nd;
    logic [SW-1:0] v;
    length_in = '0; play_in = 1'b1;
    tick(); tick();
    n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", busy_out); end
    strobe();
    watch(20, lat, v, nv, nd);
    n_vec++; if (nv !== 0 || busy_out !== 1'b0) begin n_err++; $display("FAIL zero_valid: got %0d samples busy %b want 0/0", nv, busy_out); end
    play_in = 1'b0;
    tick();
  endtask

  task automatic test_overrun();
    int lat, nv, nd;
    logic [SW-1:0] v;
    length_in = 16'd4; play_in = 1'b1;
    tick();
    n_vec++; if (overrun_out !== 1'b0) begin n_err++; $display("FAIL overrun_pre: got %b want 0", overrun_out); end
    strobe();
    tick();
    strobe();
    watch(99, lat, v, nv, nd);
    n_vec++; if (nv !== 1 || lat !== 2 || v !== 8'd5) begin n_err++; $display("FAIL overrun_samples: got n=%0d lat=%0d val=%0d want 1/2/5", nv, lat, v); end
    n_vec++; if (overrun_out !== 1'b1) begin n_err++; $display("FAIL overrun_set: got %b want 1", overrun_out); end
    strobe();
    tick();
    n_vec++; if (overrun_out !== 1'b1 || mem_addr_out !== 16'd1) begin n_err++; $display("FAIL overrun_sticky: got ovr %b addr %0d want 1/1", overrun_out, mem_addr_out); end
    rst_in = 1'b0;
    tick();
    n_vec++; if (overrun_out !== 1'b0 || busy_out !== 1'b0) begin n_err++; $display("FAIL overrun_reset: got ovr %b busy %b want 0/0", overrun_out, busy_out); end
    n_vec++; if (mem_addr_out !== '0 || position_out !== '0) begin n_err++; $display("FAIL midfetch_reset: got addr %0d pos %0d want 0/0", mem_addr_out, position_out); end
    rst_in = 1'b1; play_in = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; play_in = 1'b0; loop_in = 1'b0; echo_en_in = 1'b0;
    length_in = '0; audio_valid_in = 1'b0;
    test_reset();
    test_one_shot();
    test_loop();
    test_echo_sat();
    test_abort();
    test_zero_length();
    test_overrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
